axi_to_ndata_serializer: RTL and testbench

Converts a wide AXI4S stream into a narrower ndata stream by emitting each input beat as RATIO consecutive output slices of NUM_ELEMENTS elements each. It generalises the earlier AXI-to-ndata adaptation, which supported only a 1:1 or 2:1 ratio, to any power-of-two ratio. It adds a registered output and, optionally, suppression of empty trailing slices. It sits between wide memory- or network-facing AXI4S ports and element-wise ndata processing pipelines.

---
 rtl/stream_pkg.sv | 24 ++
 rtl/axi_to_ndata_serializer_if.sv | 27 ++
 rtl/ndata_last_slice_finder.sv | 20 ++
 rtl/axi_to_ndata_serializer.sv | 137 +++++++++++++
 tb/tb_axi_to_ndata_serializer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared stream helpers: element keep sampling and slice-index width.
package stream_pkg;

  // Widest tkeep the sampler accepts (2048-bit AXI stream).
  localparam int unsigned MaxKeepW = 256;

  // Width of a slice index for a given ratio; never narrower than one bit.
  function automatic int unsigned IDX_W(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Keep of one element: only the lowest byte of the element is sampled.
  function automatic logic keep_lsb(input logic [MaxKeepW-1:0] tkeep,
                                    input int unsigned          elem_bytes,
                                    input int unsigned          elem_idx);
    int unsigned pos;
    pos = elem_idx * elem_bytes;
    if (pos < MaxKeepW) begin
      return tkeep[pos[7:0]];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/axi_to_ndata_serializer_if.sv
// Stream interfaces: wide AXI4S input and narrow ndata element output.
interface AXI4S #(
  parameter int unsigned AXI_WIDTH = 512
);
  logic [AXI_WIDTH-1:0]   tdata;
  logic [AXI_WIDTH/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport m (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport s (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

interface ndata_i #(
  parameter type         data_t       = logic [31:0],
  parameter int unsigned NUM_ELEMENTS = 4
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport m (output data, output keep, output last, output valid, input ready);
  modport s (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/ndata_last_slice_finder.sv
// Priority encoder: index of the highest set slice-nonempty flag, 0 when none is set.
module ndata_last_slice_finder #(
  parameter int unsigned Ratio = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [Ratio-1:0] i_flags,
  output logic [IdxW-1:0]  o_idx
);

  // Later (higher) set flags override earlier ones.
  always_comb begin
    o_idx = '0;
    for (int unsigned s = 0; s < Ratio; s++) begin
      if (i_flags[s]) begin
        o_idx = IdxW'(s);
      end
    end
  end

endmodule

// File: rtl/axi_to_ndata_serializer.sv
// Wide AXI4S to narrow ndata serializer: each input beat leaves as RATIO slices.
// Optional feature macro AXI_TO_NDATA_SKIP_EMPTY_EN: on tlast beats, trailing slices
// whose sampled keep is all-zero are not emitted.
module axi_to_ndata_serializer
  import stream_pkg::*;
#(
  parameter type         data_t       = logic [31:0],
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned AXI_WIDTH    = 512
) (
  input  logic clk,
  input  logic rst_n,
  AXI4S.s      in,
  ndata_i.m    out
);

  localparam int unsigned DATA_WIDTH       = $bits(data_t);
  localparam int unsigned NUM_AXI_ELEMENTS = AXI_WIDTH / DATA_WIDTH;
  localparam int unsigned RATIO            = NUM_AXI_ELEMENTS / NUM_ELEMENTS;
  localparam int unsigned IdxW             = IDX_W(RATIO);
  localparam int unsigned KeepW            = AXI_WIDTH / 8;
  localparam int unsigned ElemBytes        = DATA_WIDTH / 8;
  localparam int unsigned SliceW           = NUM_ELEMENTS * DATA_WIDTH;
  localparam logic [IdxW-1:0] FullLastIdx  = IdxW'(RATIO - 1);

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((AXI_WIDTH % DATA_WIDTH) != 0 || (NUM_AXI_ELEMENTS % NUM_ELEMENTS) != 0) begin : g_bad_div
    $error("AXI_WIDTH must divide into a whole number of output beats");
  end
  if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("RATIO must be a power of two and at least 1");
  end
  if (KeepW > MaxKeepW) begin : g_bad_keep
    $error("AXI_WIDTH exceeds the keep sampler range");
  end

  logic [AXI_WIDTH-1:0]    r_data;
  logic [KeepW-1:0]        r_keep;
  logic                    r_tlast;
  logic                    r_full;
  logic [IdxW-1:0]         r_idx;
  logic [IdxW-1:0]         r_last_idx;

  logic                    w_fire;
  logic                    w_at_last;
  logic                    w_final_fire;
  logic                    w_tready;
  logic                    w_accept;
  logic [IdxW-1:0]         w_load_last_idx;
  logic [SliceW-1:0]       w_slice;
  logic [NUM_ELEMENTS-1:0] w_keep;

  assign w_fire       = r_full && out.ready;
  assign w_at_last    = (r_idx == r_last_idx);
  assign w_final_fire = w_fire && w_at_last;
  // Reloading in the final slice cycle keeps back-to-back beats bubble-free.
  assign w_tready     = rst_n && (!r_full || w_final_fire);
  assign w_accept     = in.tvalid && w_tready;

`ifdef AXI_TO_NDATA_SKIP_EMPTY_EN
  logic [RATIO-1:0] w_nonempty;
  logic [IdxW-1:0]  w_high_idx;

  // Flag each slice of the incoming beat that has any sampled keep bit set.
  always_comb begin
    w_nonempty = '0;
    for (int unsigned s = 0; s < RATIO; s++) begin
      for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
        if (keep_lsb(MaxKeepW'(in.tkeep), ElemBytes, s * NUM_ELEMENTS + i)) begin
          w_nonempty[s] = 1'b1;
        end
      end
    end
  end

  ndata_last_slice_finder #(
    .Ratio (RATIO),
    .IdxW  (IdxW)
  ) u_last_slice_finder (
    .i_flags (w_nonempty),
    .o_idx   (w_high_idx)
  );

  // Only final beats of a packet are trimmed; an all-empty one still emits slice 0.
  assign w_load_last_idx = in.tlast ? w_high_idx : FullLastIdx;
`else
  assign w_load_last_idx = FullLastIdx;
`endif

  // Select the current slice and sample one keep bit per element.
  always_comb begin
    w_slice = '0;
    w_keep  = '0;
    for (int unsigned s = 0; s < RATIO; s++) begin
      if (r_idx == IdxW'(s)) begin
        w_slice = r_data[s*SliceW +: SliceW];
        for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
          w_keep[i] = keep_lsb(MaxKeepW'(r_keep), ElemBytes, s * NUM_ELEMENTS + i);
        end
      end
    end
  end

  // Holding register, occupancy flag and slice index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_keep     <= '0;
      r_tlast    <= 1'b0;
      r_full     <= 1'b0;
      r_idx      <= '0;
      r_last_idx <= '0;
    end else if (w_accept) begin
      r_data     <= in.tdata;
      r_keep     <= in.tkeep;
      r_tlast    <= in.tlast;
      r_full     <= 1'b1;
      r_idx      <= '0;
      r_last_idx <= w_load_last_idx;
    end else if (w_fire) begin
      if (!w_at_last) begin
        r_idx <= r_idx + 1'b1;
      end else begin
        r_full <= 1'b0;
      end
    end
  end

  assign in.tready = w_tready;
  assign out.data  = w_slice;
  assign out.valid = r_full;
  assign out.keep  = r_full ? w_keep : '0;
  assign out.last  = r_full && r_tlast && w_at_last;

endmodule

// File: tb/tb_axi_to_ndata_serializer.sv
// Self-checking bench for axi_to_ndata_serializer (32-bit elements, 4 per beat, RATIO=4).
module tb_axi_to_ndata_serializer;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } slice_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ready_mode = 0;
  bit   mon_en = 1'b0;
  slice_t exp_q[$];

  AXI4S #(.AXI_WIDTH(512)) axi_in ();
  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(4)) nd_out ();

  axi_to_ndata_serializer #(
    .data_t       (logic [31:0]),
    .NUM_ELEMENTS (4),
    .AXI_WIDTH    (512)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (axi_in),
    .out   (nd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference: a beat becomes its slices; with trimming, a tlast beat stops at the
  // highest slice holding any sampled keep (at least one slice).
  task automatic model_push(input logic [511:0] d, input logic [63:0] k, input logic l);
    int     n = 4;
    slice_t s;
`ifdef AXI_TO_NDATA_SKIP_EMPTY_EN
    if (l) begin
      n = 1;
      for (int j = 0; j < 4; j++) begin
        for (int i = 0; i < 4; i++) begin
          if (k[(j*4+i)*4]) n = j + 1;
        end
      end
    end
`endif
    for (int j = 0; j < n; j++) begin
      s.data = d[j*128 +: 128];
      for (int i = 0; i < 4; i++) s.keep[i] = k[(j*4+i)*4];
      s.last = l && (j == n - 1);
      exp_q.push_back(s);
    end
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Keep covering 0..4 leading full slices over random bits.
  function automatic logic [63:0] rand_keep();
    logic [63:0] k;
    int unsigned n;
    k = {$urandom, $urandom};
    n = $urandom_range(0, 4);
    if (n < 4) k = k & ((64'h1 << (16 * n)) - 64'h1);
    return k;
  endfunction

  // Output ready pattern: 0 = held high, 1 = toggling, 2 = random.
  initial begin
    nd_out.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       nd_out.ready = 1'b1;
        1:       nd_out.ready = ~nd_out.ready;
        default: nd_out.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every valid slice must equal the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else if (mon_en) begin
        if (nd_out.valid) begin
          check("slice_pending", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            check("slice_data", nd_out.data, exp_q[0].data);
            check("slice_keep", 128'(nd_out.keep), 128'(exp_q[0].keep));
            check("slice_last", 128'(nd_out.last), 128'(exp_q[0].last));
            if (nd_out.ready) void'(exp_q.pop_front());
          end
        end else begin
          check("idle_keep", 128'(nd_out.keep), 128'd0);
          check("idle_last", 128'(nd_out.last), 128'd0);
        end
        if (axi_in.tvalid && axi_in.tready) model_push(axi_in.tdata, axi_in.tkeep, axi_in.tlast);
      end
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit done = 1'b0;
    axi_in.tdata  = d;
    axi_in.tkeep  = k;
    axi_in.tlast  = l;
    axi_in.tvalid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (axi_in.tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 128'(done), 128'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !nd_out.valid) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("drain_done", 128'(ok), 128'd1);
  endtask

  initial begin
    logic [511:0] d;
    int           acc;
    int           cnt;
    bit           hs;

    axi_in.tdata  = '0;
    axi_in.tkeep  = '0;
    axi_in.tlast  = 1'b0;
    axi_in.tvalid = 1'b0;

    // Reset state.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_valid", 128'(nd_out.valid), 128'd0);
      check("rst_tready", 128'(axi_in.tready), 128'd0);
      check("rst_keep", 128'(nd_out.keep), 128'd0);
      check("rst_last", 128'(nd_out.last), 128'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready", 128'(axi_in.tready), 128'd1);
    check("rel_valid", 128'(nd_out.valid), 128'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Counting words, full keep: four slices right after acceptance, last on the 4th.
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = 32'(w);
    send_beat(d, '1, 1'b1);
    axi_in.tvalid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("cnt_valid", 128'(nd_out.valid), 128'd1);
      check("cnt_data", nd_out.data,
            {32'(s*4+3), 32'(s*4+2), 32'(s*4+1), 32'(s*4)});
      check("cnt_keep", 128'(nd_out.keep), 128'hF);
      check("cnt_last", 128'(nd_out.last), 128'(s == 3));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("cnt_after_valid", 128'(nd_out.valid), 128'd0);
    @(posedge clk);
    #1;
    drain();

    // Three back-to-back beats: 12 valid cycles, tready only every 4th cycle.
    acc = 0;
    axi_in.tdata  = rand_data();
    axi_in.tkeep  = '1;
    axi_in.tlast  = 1'b0;
    axi_in.tvalid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 12) check("b2b_tready", 128'(axi_in.tready), 128'((c % 4) == 0));
      check("b2b_valid", 128'(nd_out.valid), 128'(c >= 1 && c <= 12));
      hs = axi_in.tvalid && axi_in.tready;
      @(posedge clk);
      #1;
      if (hs) begin
        acc++;
        if (acc < 3) begin
          axi_in.tdata = rand_data();
          axi_in.tlast = (acc == 2);
        end else begin
          axi_in.tvalid = 1'b0;
        end
      end
    end
    drain();

    // Toggling ready: slices must hold while stalled, none lost or repeated.
    ready_mode = 1;
    for (int b = 0; b < 3; b++) send_beat(rand_data(), rand_keep(), 1'(b == 2));
    axi_in.tvalid = 1'b0;
    drain();

    // Only the lowest slice carries keep.
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_beat(rand_data(), 64'h0000_0000_0000_FFFF, 1'b1);
    axi_in.tvalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (nd_out.valid) cnt++;
      @(posedge clk);
      #1;
    end
`ifdef AXI_TO_NDATA_SKIP_EMPTY_EN
    check("sparse_slices", 128'(cnt), 128'd1);
`else
    check("sparse_slices", 128'(cnt), 128'd4);
`endif
    drain();

    // Reset while slice 2 is presented, then restart cleanly at slice 0.
    d = rand_data();
    send_beat(d, '1, 1'b1);
    axi_in.tvalid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_slice2_data", nd_out.data, d[256 +: 128]);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_valid", 128'(nd_out.valid), 128'd0);
    check("mid_rst_tready", 128'(axi_in.tready), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = rand_data();
    send_beat(d, '1, 1'b0);
    axi_in.tvalid = 1'b0;
    @(negedge clk);
    check("restart_valid", 128'(nd_out.valid), 128'd1);
    check("restart_data", nd_out.data, d[127:0]);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic with random backpressure and input gaps.
    ready_mode = 2;
    for (int b = 0; b < 40; b++) begin
      send_beat(rand_data(), rand_keep(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        axi_in.tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    axi_in.tvalid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
